// File: rtl/insn_cracker_pkg.sv
// insn_cracker_pkg: PowerPC opcode/XO constants, field slices and update-form to base-form mapping.
package insn_cracker_pkg;
  typedef enum logic [1:0] {IDLE, UPD, MW} state_t;
  typedef enum logic [1:0] {K_PASS, K_UPD, K_MW} kind_t;
  localparam int MW_STEP_DEF = 4;
  localparam logic [5:0] OP_ADDI = 6'd14, OP_X = 6'd31, OP_LWZ = 6'd32, OP_STW = 6'd36;
  localparam logic [5:0] OP_LMW = 6'd46, OP_STMW = 6'd47, OP_LD = 6'd58, OP_STD = 6'd62;
  localparam logic [8:0] XO_ADD = 9'd266;
  localparam logic [9:0] XO_UPD_DELTA = 10'd32;
  localparam logic [1:0] DS_UPD = 2'd1;
  function automatic logic [5:0] f_op(input logic [31:0] i);
    return i[31:26];
  endfunction
  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[25:21];
  endfunction
  function automatic logic [4:0] f_ra(input logic [31:0] i);
    return i[20:16];
  endfunction
  function automatic logic [9:0] f_xo(input logic [31:0] i);
    return i[10:1];
  endfunction
  function automatic logic ds_form(input logic [31:0] i);
    return f_op(i) inside {OP_LD, OP_STD};
  endfunction
  function automatic logic upd_d(input logic [31:0] i);
    return f_op(i) inside {6'd33, 6'd35, 6'd37, 6'd39, 6'd41, 6'd43, 6'd45} || (ds_form(i) && i[1:0] == DS_UPD);
  endfunction
  function automatic logic upd_x(input logic [31:0] i);
    return f_op(i) == OP_X && f_xo(i) inside {10'd53, 10'd55, 10'd119, 10'd181, 10'd183, 10'd247, 10'd311, 10'd373, 10'd375, 10'd439};
  endfunction
  function automatic logic upd_load(input logic [31:0] i);
    return f_op(i) inside {6'd33, 6'd35, 6'd41, 6'd43, OP_LD} || (f_op(i) == OP_X && f_xo(i) inside {10'd53, 10'd55, 10'd119, 10'd311, 10'd373, 10'd375});
  endfunction
  // Base form: D opcode minus one, DS sub-opcode cleared, X-form XO minus 32
  function automatic logic [31:0] upd_base(input logic [31:0] i);
    if (f_op(i) == OP_X) return {i[31:11], f_xo(i) - XO_UPD_DELTA, i[0]};
    if (ds_form(i)) return {i[31:2], 2'b00};
    return {f_op(i) - 6'd1, i[25:0]};
  endfunction
  function automatic logic [31:0] upd_inc(input logic [31:0] i);
    if (f_op(i) == OP_X) return {OP_X, f_ra(i), f_ra(i), i[15:11], 1'b0, XO_ADD, 1'b0};
    return {OP_ADDI, f_ra(i), f_ra(i), i[15:2], ds_form(i) ? 2'b00 : i[1:0]};
  endfunction
  function automatic logic add_ovf(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s = a + b;
    return a[15] == b[15] && s[15] != a[15];
  endfunction
endpackage

// File: rtl/insn_crack_decode.sv
// insn_crack_decode: classifies an instruction and builds its first two micro-op encodings.
module insn_crack_decode
  import insn_cracker_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int UPD_EN = 1,
  parameter int MW_EN = 1
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output kind_t                  kind,
  output logic [INSTR_WIDTH-1:0] uop0,
  output logic [INSTR_WIDTH-1:0] uop1,
  output logic                   illegal,
  output logic [4:0]             rt
);
  logic [31:0] w;
  logic upd, mw, lmw;
  always_comb begin
    w = instr[31:0];
    upd = UPD_EN != 0 && (upd_d(w) || upd_x(w));
    mw = MW_EN != 0 && (f_op(w) == OP_LMW || f_op(w) == OP_STMW);
    lmw = f_op(w) == OP_LMW;
    rt = f_rt(w);
    kind = upd ? K_UPD : mw ? K_MW : K_PASS;
    uop0 = upd ? INSTR_WIDTH'(upd_base(w)) : mw ? INSTR_WIDTH'({lmw ? OP_LWZ : OP_STW, w[25:0]}) : instr;
    uop1 = INSTR_WIDTH'(upd_inc(w));
    illegal = upd ? (f_ra(w) == 5'd0 || (upd_load(w) && f_ra(w) == f_rt(w)))
                  : mw && lmw && (f_ra(w) == 5'd0 || f_ra(w) >= f_rt(w));
  end
endmodule

// File: rtl/insn_cracker.sv
// insn_cracker: cracks update-form loads/stores and lmw/stmw into a registered micro-op stream.
module insn_cracker
  import insn_cracker_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter int UPD_EN = 1,
  parameter int MW_EN = 1,
  parameter int MW_STEP = MW_STEP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]    in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   out_illegal,
  output logic                   busy
);
  localparam logic [15:0] STEP = 16'(MW_STEP);
  state_t state, state_n;
  kind_t kind;
  logic [INSTR_WIDTH-1:0] uop0, uop1, pend, mw_uop;
  logic [4:0] rt, rem, rcnt;
  logic [15:0] off, off_n, src;
  logic d_ill, seq_ill, ovf, ovf_n, adv, acc, last_mw;
  insn_crack_decode #(.INSTR_WIDTH(INSTR_WIDTH), .UPD_EN(UPD_EN), .MW_EN(MW_EN)) u_dec (
    .instr(in_instr), .kind(kind), .uop0(uop0), .uop1(uop1), .illegal(d_ill), .rt(rt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (adv)
      state_n = state == IDLE ? (!acc ? IDLE : kind == K_UPD ? UPD : kind == K_MW && rt != 5'd31 ? MW : IDLE)
              : state == MW && !last_mw ? MW : IDLE;
  end
  always_comb begin
    adv = !out_valid || out_ready;
    in_ready = state == IDLE && adv && !flush;
    acc = in_valid && in_ready;
    busy = state != IDLE;
    last_mw = rem == 5'd1;
    src = state == IDLE ? in_instr[15:0] : off;
    off_n = src + STEP;
    ovf_n = (state == MW && ovf) | add_ovf(src, STEP);
    mw_uop = INSTR_WIDTH'({out_instr[31:26], rcnt, out_instr[20:16], off});
  end
  // The output register doubles as the opcode/RA template for later lmw/stmw micro-ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      out_illegal <= 1'b0;
      pend <= '0;
      seq_ill <= 1'b0;
      rem <= '0;
      rcnt <= '0;
      off <= '0;
      ovf <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rem <= '0;
      rcnt <= '0;
      off <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      if (state == IDLE) begin
        out_valid <= acc;
        if (acc) begin
          out_instr <= uop0;
          out_pc <= in_pc;
          out_first <= 1'b1;
          out_last <= kind == K_PASS || (kind == K_MW && rt == 5'd31);
          out_illegal <= d_ill;
          pend <= uop1;
          seq_ill <= d_ill;
          rem <= 5'd31 - rt;
          rcnt <= rt + 5'd1;
          off <= off_n;
          ovf <= ovf_n;
        end
      end else begin
        out_instr <= state == UPD ? pend : mw_uop;
        out_first <= 1'b0;
        out_last <= state == UPD || last_mw;
        out_illegal <= seq_ill | (state == MW && ovf);
        if (state == MW) begin
          rem <= rem - 5'd1;
          rcnt <= rcnt + 5'd1;
          off <= off_n;
          ovf <= ovf_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_insn_cracker.sv
// tb_insn_cracker: scoreboard bench with a table-driven reference model of the cracking rules.
module tb_insn_cracker;
  localparam int STEP = 4;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_first, out_last, out_illegal, busy;
  logic [31:0] in_instr = 0, in_pc = 0, out_instr, out_pc;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic first, last, ill;} uop_t;
  uop_t sb[$];
  uop_t held, cur, e;
  logic stalled = 0;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  insn_cracker dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_first(out_first), .out_last(out_last),
    .out_illegal(out_illegal), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int d_base(input int op);
    case (op)
      33: return 32; 35: return 34; 37: return 36; 39: return 38;
      41: return 40; 43: return 42; 45: return 44;
      default: return -1;
    endcase
  endfunction

  function automatic int x_base(input int xo);
    case (xo)
      55: return 23; 119: return 87; 183: return 151; 247: return 215; 311: return 279;
      375: return 343; 439: return 407; 53: return 21; 181: return 149; 373: return 341;
      default: return -1;
    endcase
  endfunction

  function automatic uop_t mk(input logic [31:0] i, input logic [31:0] pc, input logic f, input logic l, input logic il);
    return '{i, pc, f, l, il};
  endfunction

  task automatic model(input logic [31:0] i, input logic [31:0] pc);
    int op = int'(i[31:26]), rt = int'(i[25:21]), ra = int'(i[20:16]), xo = int'(i[10:1]);
    logic [31:0] u, v;
    logic il, ds;
    int o;
    ds = (op == 58 || op == 62) && i[1:0] == 2'd1;
    if (op == 31 && x_base(xo) >= 0) begin
      il = ra == 0 || (xo inside {55, 119, 311, 375, 53, 373} && ra == rt);
      u = i;
      u[10:1] = 10'(x_base(xo));
      v = {6'd31, i[20:16], i[20:16], i[15:11], 1'b0, 9'd266, 1'b0};
      sb.push_back(mk(u, pc, 1, 0, il));
      sb.push_back(mk(v, pc, 0, 1, il));
    end else if (d_base(op) >= 0 || ds) begin
      il = ra == 0 || (op inside {33, 35, 41, 43, 58} && ra == rt);
      u = i;
      v = {6'd14, i[20:16], i[20:16], i[15:0]};
      if (ds) begin
        u[1:0] = 2'd0;
        v[1:0] = 2'd0;
      end else u[31:26] = 6'(d_base(op));
      sb.push_back(mk(u, pc, 1, 0, il));
      sb.push_back(mk(v, pc, 0, 1, il));
    end else if (op == 46 || op == 47) begin
      il = op == 46 && (ra == 0 || ra >= rt);
      for (int k = 0; k <= 31 - rt; k++) begin
        o = int'($signed(i[15:0])) + k * STEP;
        u = {op == 46 ? 6'd32 : 6'd36, 5'(rt + k), i[20:16], o[15:0]};
        sb.push_back(mk(u, pc, k == 0, k == 31 - rt, il || o > 32767));
      end
    end else sb.push_back(mk(i, pc, 1, 1, 0));
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] i = $urandom;
    int dl[7] = '{33, 35, 37, 39, 41, 43, 45};
    int xl[10] = '{55, 119, 183, 247, 311, 375, 439, 53, 181, 373};
    case ($urandom_range(0, 5))
      1: begin i[31:26] = 6'(dl[$urandom_range(0, 6)]); i[25:21] = 5'($urandom_range(0, 3)); i[20:16] = 5'($urandom_range(0, 3)); end
      2: begin i[31:26] = $urandom_range(0, 1) ? 6'd58 : 6'd62; i[1:0] = 2'($urandom_range(0, 2)); i[25:21] = 5'($urandom_range(0, 3)); i[20:16] = 5'($urandom_range(0, 3)); end
      3: begin i[31:26] = 6'd31; i[10:1] = 10'(xl[$urandom_range(0, 9)]); i[25:21] = 5'($urandom_range(0, 3)); i[20:16] = 5'($urandom_range(0, 3)); end
      4: begin
        i[31:26] = $urandom_range(0, 1) ? 6'd46 : 6'd47;
        i[25:21] = 5'($urandom_range(24, 31));
        if ($urandom_range(0, 2) == 0) i[15:0] = 16'h7FF0 + 16'($urandom_range(0, 15));
      end
      5: begin i[31:26] = 6'd31; i[10:1] = 10'd266; end
      default: ;
    endcase
    return i;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc, input logic ordy, input logic fl, output logic acc);
    @(posedge clk);
    #1;
    in_valid = iv;
    in_instr = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) model(ins, pc);
    if (fl) sb.delete();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int tries);
    logic acc = 0;
    tries = 0;
    while (!acc && tries < 100) begin
      drive(1, ins, pc, 1, 0, acc);
      tries++;
    end
    chk("accept", 128'(acc), 128'd1);
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) drive(0, 0, 0, 1, 0, a);
  endtask

  always @(negedge clk) begin
    cur = '{out_instr, out_pc, out_first, out_last, out_illegal};
    if (rst) stalled = 0;
    else begin
      if (stalled) chk("hold_stable", 128'(cur), 128'(held));
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_uop: got %h with no expected micro-op pending", cur);
        end else begin
          e = sb.pop_front();
          chk("uop", 128'(cur), 128'(e));
        end
      end
      stalled = out_valid && !out_ready && !flush;
      held = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    logic a, rv, fl;
    logic [31:0] ri, rp;
    int t, guard;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 128'({out_valid, out_instr, out_pc, out_first, out_last, out_illegal, busy}), 128'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    send(32'h84640008, 32'h100, t);
    drive(0, 0, 0, 1, 0, a);
    chk("upd_in_ready_low", 128'(in_ready), 128'd0);
    chk("upd_busy", 128'(busy), 128'd1);
    drive(0, 0, 0, 1, 0, a);
    chk("upd_in_ready_back", 128'(in_ready), 128'd1);
    idle(2);
    send(32'hBBA10010, 32'h200, t);
    idle(4);
    send(32'hBFE10000, 32'h300, t);
    send(32'h7C632214, 32'h304, t);
    chk("b2b_tries", 128'(t), 128'd1);
    idle(2);
    send(32'hBBA10010, 32'h400, t);
    drive(0, 0, 0, 1, 0, a);
    repeat (3) begin
      drive(0, 0, 0, 0, 0, a);
      chk("bp_hold_instr", 128'(out_instr), 128'h83C10014);
    end
    idle(4);
    send(32'hBBA10010, 32'h500, t);
    drive(0, 0, 0, 1, 0, a);
    drive(0, 0, 0, 1, 1, a);
    chk("flush_in_ready", 128'(in_ready), 128'd0);
    drive(0, 0, 0, 1, 0, a);
    chk("flush_valid", 128'(out_valid), 128'd0);
    chk("flush_busy", 128'(busy), 128'd0);
    send(32'h7C632214, 32'h504, t);
    idle(2);
    send(32'h84000004, 32'h600, t);
    idle(3);
    send(32'hBBA10010, 32'h700, t);
    drive(0, 0, 0, 1, 0, a);
    @(posedge clk);
    #2 rst = 1;
    sb.delete();
    #1;
    chk("rst_async", 128'({out_valid, out_instr, out_pc, out_first, out_last, out_illegal, busy}), 128'd0);
    @(posedge clk);
    #1 rst = 0;
    rv = 0;
    a = 0;
    ri = 0;
    rp = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!rv || a) begin
        rv = $urandom_range(0, 9) < 7;
        ri = gen();
        rp = $urandom;
      end
      fl = $urandom_range(0, 49) == 0;
      drive(rv, ri, rp, $urandom_range(0, 3) != 0, fl, a);
    end
    guard = 0;
    while (sb.size() > 0 && guard < 300) begin
      drive(0, 0, 0, 1, 0, a);
      guard++;
    end
    chk("drain_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/insn_cracker.md
Name: insn_cracker

Overview:
Parametrised successor to the fetch-side instruction converter. It cracks PowerPC update-form loads/stores (D- and X-form) and lmw/stmw into simple micro-ops. It uses explicit valid/ready handshakes on both sides instead of PC-change detection, and supports a pipeline flush. It sits between fetch and decode and drives one registered micro-op per cycle.

Parameters:
INSTR_WIDTH, 32, instruction/micro-op width
PC_WIDTH, 32, PC width
UPD_EN, 1, 1 = crack update forms; 0 = pass them through unchanged
MW_EN, 1, 1 = crack lmw/stmw; 0 = pass them through unchanged
MW_STEP, 4, byte offset increment between lmw/stmw micro-ops

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of the in-flight sequence and the output register
in_valid  in  1  fetch presents instruction
in_ready  out  1  block accepts the instruction this cycle
in_instr  in  INSTR_WIDTH  fetched instruction
in_pc  in  PC_WIDTH  PC of in_instr
out_valid  out  1  micro-op valid
out_ready  in  1  decode consumes the micro-op
out_instr  out  INSTR_WIDTH  micro-op encoding
out_pc  out  PC_WIDTH  PC of the parent instruction (the same for every micro-op of a sequence)
out_first  out  1  first micro-op of its parent
out_last  out  1  last micro-op of its parent (1 for pass-through)
out_illegal  out  1  invalid form or offset overflow on this micro-op
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0; out_instr=0; out_pc=0; out_first=0; out_last=0; out_illegal=0; counters=0.
- Output register advance condition: adv = !out_valid || out_ready.
- in_ready = (state==IDLE) && adv && !flush.
- Latency: an accepted instruction's first micro-op appears on out_* the next cycle.
- Accept with a non-cracked opcode: pass through unchanged; first=last=1.
- Update forms: lbzu/ldu/lhau/lhzu/lwzu/stbu/stdu/sthu/stwu and lbzux/ldux/lhaux/lhzux/lwzux/lwaux/stbux/stdux/sthux/stwux.
  - Micro-op 0: base access (lbz/ld/…/stwx), same RT/RS, RA, D or RB.
  - Micro-op 1: addi RA,RA,D (D-form) or add RA,RA,RB with OE=0, Rc=0 (X-form).
  - State goes UPD until micro-op 1 is advanced out.
  - RA==0, or RA==RT on loads: out_illegal=1 on both micro-ops; sequence still emitted.
- lmw/stmw RT=r: emit 32-r micro-ops, lwz/stw (r+k), RA, D+k*MW_STEP, for k=0..31-r.
  - r=31: single micro-op, first=last=1, state stays IDLE.
  - Otherwise state goes MW, with a 5-bit remaining-count, a register counter and a 16-bit offset counter.
  - Offset arithmetic is 16-bit two's-complement. Any micro-op whose offset overflows signed 16 bits relative to D sets out_illegal (value wraps mod 2^16).
  - lmw with RA in [r,31] or RA==0: out_illegal on all micro-ops.
- States:
  - IDLE→UPD on accepting an update form.
  - IDLE→MW on accepting lmw/stmw with r<31.
  - UPD→IDLE and MW→IDLE when the last micro-op loads into the output register.
- out_ready=0: out_* hold stable and counters do not advance. Back-to-back instructions are accepted with no bubble when out_ready=1 and the last micro-op is loading.
- Flush is synchronous and has priority over everything except rst. Next cycle: out_valid=0, state=IDLE, counters cleared. in_ready=0 during the flush cycle.
- Opcode and XO decoding uses the existing instruction-definition macros. UPD_EN=0 or MW_EN=0 removes the corresponding decode, so those opcodes pass through.

Decomposition:
- Shared package/include: existing opcode/XO macros and field-slice macros.
- New constants to add there: update-form→base-form opcode map and MW_STEP default.
- One sub-module, insn_crack_decode: combinational classification plus generation of micro-op 0/1 encodings. The sequencer FSM, counters and output register stay in insn_cracker.

Test Plan:
- lwzu r3,8(r4): in_instr=0x84640008, PC=0x100, out_ready=1 → 0x80640008 (first=1), then 0x38840008 (last=1), out_pc=0x100 both; in_ready low for 1 cycle.
- lmw r29,16(r1)=0xBBA10010 → 0x83A10010, 0x83C10014, 0x83E10018 on consecutive cycles; first on 1st, last on 3rd; illegal=0.
- lmw r31,0(r1)=0xBFE10000 → single 0x83E10000 with first=last=1; next instruction accepted the same cycle it issues.
- Backpressure: out_ready=0 for 3 cycles during the 2nd lmw micro-op → 0x83C10014 held stable, no skipped or duplicated micro-op after release.
- Flush asserted while lmw r29 is emitting its 2nd micro-op → out_valid=0 next cycle, busy=0; a following add passes through unchanged.
- lwzu r0,4(r0)=0x80000004|opcode 33 (0x84000004) → both micro-ops carry out_illegal=1; rst asserted mid-sequence → all outputs are 0 immediately.
